// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with a data-memory access FSM.
// Optional build macro: MISALIGN_TRAP_EN (misaligned accesses trap instead of issuing).
module ex_mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic        valid_in,
  input  logic [31:0] alu_in,
  input  logic        br_en_in,
  input  logic [31:0] rs2_in,
  input  logic [31:0] pc_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  funct3_in,
  input  logic [4:0]  rd_in,
  input  logic [3:0]  regfilemux_sel_in,
  output logic        valid_out,
  output logic [31:0] alu_out,
  output logic        br_en_out,
  output logic [31:0] pc_out,
  output logic [4:0]  rd_out,
  output logic [3:0]  regfilemux_sel_out,
  output logic [31:0] data_mem_address,
  output logic [31:0] data_mem_wdata,
  output logic [3:0]  data_mem_mbe,
  output logic        data_mem_read,
  output logic        data_mem_write,
  input  logic        data_mem_resp,
  input  logic [31:0] data_mem_rdata,
  output logic [31:0] mem_rdata_out,
  output logic        mem_stall,
  output logic        misaligned_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e      state_q, state_d;
  logic        valid_q, valid_d, br_en_q, br_en_d;
  logic [31:0] alu_q, alu_d, rs2_q, rs2_d, pc_q, pc_d, mem_rdata_q, mem_rdata_d;
  logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic [3:0]  rfsel_q, rfsel_d;
  logic        flush_pend_q, flush_pend_d;
  logic        capture, mem_op, trap;
  logic [3:0]  mbe_raw;
  logic [31:0] wdata_raw;

  assign capture = (state_q != ACCESS) && load;
  assign mem_op  = valid_in && !flush && (mem_read_in || mem_write_in);

`ifdef MISALIGN_TRAP_EN
  logic misaligned_q, misaligned_d, capture_misaligned;

  always_comb begin
    capture_misaligned = 1'b0;
    case (funct3_in)
      3'b001, 3'b101: capture_misaligned = alu_in[0];
      3'b010:         capture_misaligned = (alu_in[1:0] != 2'b00);
      default:        capture_misaligned = 1'b0;
    endcase
  end

  assign trap = mem_op && capture_misaligned;

  always_comb begin
    misaligned_d = misaligned_q;
    if (capture) misaligned_d = trap;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) misaligned_q <= 1'b0;
    else      misaligned_q <= misaligned_d;
  end

  assign misaligned_out = misaligned_q;
`else
  assign trap           = 1'b0;
  assign misaligned_out = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    alu_d        = alu_q;
    br_en_d      = br_en_q;
    rs2_d        = rs2_q;
    pc_d         = pc_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    funct3_d     = funct3_q;
    rd_d         = rd_q;
    rfsel_d      = rfsel_q;
    mem_rdata_d  = mem_rdata_q;
    flush_pend_d = flush_pend_q;
    case (state_q)
      IDLE, DONE: begin
        if (load) begin
          valid_d      = valid_in && !flush;
          alu_d        = alu_in;
          br_en_d      = br_en_in;
          rs2_d        = rs2_in;
          pc_d         = pc_in;
          mem_read_d   = mem_read_in;
          mem_write_d  = mem_write_in;
          funct3_d     = funct3_in;
          rd_d         = rd_in;
          rfsel_d      = regfilemux_sel_in;
          flush_pend_d = 1'b0;
          state_d      = (mem_op && !trap) ? ACCESS : IDLE;
        end
      end
      ACCESS: begin
        // A flush cannot abort the bus transaction; it only kills the result.
        if (flush) flush_pend_d = 1'b1;
        if (data_mem_resp) begin
          mem_rdata_d  = data_mem_rdata;
          valid_d      = valid_q && !(flush_pend_q || flush);
          flush_pend_d = 1'b0;
          state_d      = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      alu_q        <= '0;
      br_en_q      <= 1'b0;
      rs2_q        <= '0;
      pc_q         <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      funct3_q     <= '0;
      rd_q         <= '0;
      rfsel_q      <= '0;
      mem_rdata_q  <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      alu_q        <= alu_d;
      br_en_q      <= br_en_d;
      rs2_q        <= rs2_d;
      pc_q         <= pc_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      funct3_q     <= funct3_d;
      rd_q         <= rd_d;
      rfsel_q      <= rfsel_d;
      mem_rdata_q  <= mem_rdata_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    mbe_raw   = 4'b0000;
    wdata_raw = rs2_q;
    case (funct3_q)
      3'b000, 3'b100: begin
        mbe_raw   = 4'b0001 << alu_q[1:0];
        wdata_raw = {4{rs2_q[7:0]}};
      end
      3'b001, 3'b101: begin
        mbe_raw   = 4'b0011 << {alu_q[1], 1'b0};
        wdata_raw = {2{rs2_q[15:0]}};
      end
      3'b010: begin
        mbe_raw   = 4'b1111;
        wdata_raw = rs2_q;
      end
      default: begin
        mbe_raw   = 4'b0000;
        wdata_raw = rs2_q;
      end
    endcase
  end

  // Byte enables and write data qualify a live request, so they are quiet outside ACCESS.
  assign data_mem_mbe       = (state_q == ACCESS) ? mbe_raw : 4'b0000;
  assign data_mem_wdata     = (state_q == ACCESS) ? wdata_raw : 32'h0;
  assign data_mem_address   = {alu_q[31:2], 2'b00};
  assign data_mem_read      = (state_q == ACCESS) && mem_read_q;
  assign data_mem_write     = (state_q == ACCESS) && mem_write_q;
  assign mem_stall          = (state_q == ACCESS);
  assign valid_out          = valid_q;
  assign alu_out            = alu_q;
  assign br_en_out          = br_en_q;
  assign pc_out             = pc_q;
  assign rd_out             = rd_q;
  assign regfilemux_sel_out = rfsel_q;
  assign mem_rdata_out      = mem_rdata_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - self-checking bench for ex_mem_stage.
module tb_ex_mem_stage;
  logic        clk = 1'b0;
  logic        rst, load, flush, valid_in, br_en_in, mem_read_in, mem_write_in;
  logic [31:0] alu_in, rs2_in, pc_in, data_mem_rdata;
  logic [2:0]  funct3_in;
  logic [4:0]  rd_in;
  logic [3:0]  regfilemux_sel_in;
  logic        data_mem_resp;
  logic        valid_out, br_en_out, data_mem_read, data_mem_write, mem_stall, misaligned_out;
  logic [31:0] alu_out, pc_out, data_mem_address, data_mem_wdata, mem_rdata_out;
  logic [4:0]  rd_out;
  logic [3:0]  regfilemux_sel_out, data_mem_mbe;

  int vecs = 0;
  int errs = 0;
  logic [31:0] model_rdata = 32'h0;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .load(load), .flush(flush), .valid_in(valid_in),
    .alu_in(alu_in), .br_en_in(br_en_in), .rs2_in(rs2_in), .pc_in(pc_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .funct3_in(funct3_in),
    .rd_in(rd_in), .regfilemux_sel_in(regfilemux_sel_in),
    .valid_out(valid_out), .alu_out(alu_out), .br_en_out(br_en_out), .pc_out(pc_out),
    .rd_out(rd_out), .regfilemux_sel_out(regfilemux_sel_out),
    .data_mem_address(data_mem_address), .data_mem_wdata(data_mem_wdata),
    .data_mem_mbe(data_mem_mbe), .data_mem_read(data_mem_read), .data_mem_write(data_mem_write),
    .data_mem_resp(data_mem_resp), .data_mem_rdata(data_mem_rdata),
    .mem_rdata_out(mem_rdata_out), .mem_stall(mem_stall), .misaligned_out(misaligned_out)
  );

  // Reference model: access width in bytes from funct3 (0 = no memory access width).
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [3:0] ref_mbe(input logic [2:0] f3, input logic [31:0] alu);
    int sz, off;
    sz = size_of(f3);
    if (sz == 0) return 4'b0000;
    off = (alu % 4) - ((alu % 4) % sz);
    return 4'(((1 << sz) - 1) << off);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    case (size_of(f3))
      1:       return (rs2 % 256) * 32'h0101_0101;
      2:       return (rs2 % 65536) * 32'h0001_0001;
      default: return rs2;
    endcase
  endfunction

  function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] alu);
    int sz;
    sz = size_of(f3);
    return (sz > 1) && ((alu % sz) != 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic v, input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] pc,
                         input logic [4:0] rd, input logic [3:0] sel, input logic br, input logic fl);
    valid_in = v; mem_read_in = mr; mem_write_in = mw; funct3_in = f3; alu_in = alu;
    rs2_in = rs2; pc_in = pc; rd_in = rd; regfilemux_sel_in = sel; br_en_in = br;
    flush = fl; load = 1'b1;
    tick();
    load = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; load = 0; flush = 0; valid_in = 0; alu_in = 0; rs2_in = 0; pc_in = 0;
    br_en_in = 0; mem_read_in = 0; mem_write_in = 0; funct3_in = 0; rd_in = 0;
    regfilemux_sel_in = 0; data_mem_resp = 0; data_mem_rdata = 0;
    tick(); tick();
    vecs++; if (valid_out !== 1'b0) begin errs++; $display("FAIL reset_valid got %b want 0", valid_out); end
    vecs++; if (mem_stall !== 1'b0) begin errs++; $display("FAIL reset_stall got %b want 0", mem_stall); end
    vecs++; if ({data_mem_read, data_mem_write, misaligned_out} !== 3'b000) begin errs++; $display("FAIL reset_ctl got %b want 000", {data_mem_read, data_mem_write, misaligned_out}); end
    vecs++; if (data_mem_mbe !== 4'h0) begin errs++; $display("FAIL reset_mbe got %b want 0000", data_mem_mbe); end
    vecs++; if ({alu_out, pc_out, data_mem_address, data_mem_wdata, mem_rdata_out} !== 160'h0) begin errs++; $display("FAIL reset_data got nonzero bus want 0"); end
    vecs++; if ({rd_out, regfilemux_sel_out, br_en_out} !== 10'h0) begin errs++; $display("FAIL reset_fields got %h want 0", {rd_out, regfilemux_sel_out, br_en_out}); end
    @(negedge clk); rst = 1'b1;
    tick();
  endtask

  task automatic test_store_word();
    capture(1, 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h1000, 5'd3, 4'd2, 1'b0, 1'b0);
    vecs++; if (data_mem_address !== 32'h100) begin errs++; $display("FAIL sw_addr got %h want 00000100", data_mem_address); end
    vecs++; if (data_mem_mbe !== 4'b1111) begin errs++; $display("FAIL sw_mbe got %b want 1111", data_mem_mbe); end
    vecs++; if (data_mem_wdata !== 32'hDEADBEEF) begin errs++; $display("FAIL sw_wdata got %h want deadbeef", data_mem_wdata); end
    vecs++; if ({data_mem_write, data_mem_read, mem_stall} !== 3'b101) begin errs++; $display("FAIL sw_req got %b want 101", {data_mem_write, data_mem_read, mem_stall}); end
    data_mem_resp = 1; data_mem_rdata = 32'h0; model_rdata = 32'h0;
    tick();
    data_mem_resp = 0;
    vecs++; if ({data_mem_write, mem_stall} !== 2'b00) begin errs++; $display("FAIL sw_done got %b want 00", {data_mem_write, mem_stall}); end
    vecs++; if (valid_out !== 1'b1 || pc_out !== 32'h1000) begin errs++; $display("FAIL sw_fields got v=%b pc=%h want 1 00001000", valid_out, pc_out); end
  endtask

  task automatic test_load_byte();
    capture(1, 1, 0, 3'b000, 32'h203, 32'h0, 32'h2000, 5'd5, 4'd1, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      vecs++; if ({data_mem_read, mem_stall} !== 2'b11) begin errs++; $display("FAIL lb_read_c%0d got %b want 11", k, {data_mem_read, mem_stall}); end
      vecs++; if (data_mem_mbe !== 4'b1000) begin errs++; $display("FAIL lb_mbe_c%0d got %b want 1000", k, data_mem_mbe); end
      if (k == 3) begin data_mem_resp = 1; data_mem_rdata = 32'h11223344; model_rdata = 32'h11223344; end
      tick();
      data_mem_resp = 0;
    end
    vecs++; if ({data_mem_read, mem_stall} !== 2'b00) begin errs++; $display("FAIL lb_done got %b want 00", {data_mem_read, mem_stall}); end
    vecs++; if (mem_rdata_out !== 32'h11223344) begin errs++; $display("FAIL lb_rdata got %h want 11223344", mem_rdata_out); end
  endtask

  task automatic test_store_half();
    capture(1, 0, 1, 3'b001, 32'h302, 32'h0000ABCD, 32'h3000, 5'd7, 4'd0, 1'b1, 1'b0);
    vecs++; if (data_mem_mbe !== 4'b1100) begin errs++; $display("FAIL sh_mbe got %b want 1100", data_mem_mbe); end
    vecs++; if (data_mem_wdata !== 32'hABCDABCD) begin errs++; $display("FAIL sh_wdata got %h want abcdabcd", data_mem_wdata); end
    vecs++; if (data_mem_address !== 32'h300) begin errs++; $display("FAIL sh_addr got %h want 00000300", data_mem_address); end
    data_mem_resp = 1; data_mem_rdata = 32'h5; model_rdata = 32'h5;
    tick();
    data_mem_resp = 0;
  endtask

  task automatic test_flush_in_access();
    capture(1, 1, 0, 3'b010, 32'h400, 32'h0, 32'h4000, 5'd9, 4'd3, 1'b0, 1'b0);
    tick();
    flush = 1;
    tick();
    flush = 0;
    vecs++; if ({data_mem_read, mem_stall} !== 2'b11) begin errs++; $display("FAIL flush_not_abort got %b want 11", {data_mem_read, mem_stall}); end
    data_mem_resp = 1; data_mem_rdata = 32'hCAFEF00D; model_rdata = 32'hCAFEF00D;
    tick();
    data_mem_resp = 0;
    vecs++; if (valid_out !== 1'b0) begin errs++; $display("FAIL flush_valid got %b want 0", valid_out); end
    vecs++; if (mem_rdata_out !== 32'hCAFEF00D) begin errs++; $display("FAIL flush_rdata got %h want cafef00d", mem_rdata_out); end
    capture(1, 0, 0, 3'b000, 32'h55, 32'h0, 32'h4004, 5'd10, 4'd4, 1'b1, 1'b0);
    vecs++; if ({valid_out, mem_stall} !== 2'b10 || alu_out !== 32'h55) begin errs++; $display("FAIL flush_next got v=%b s=%b alu=%h want 1 0 00000055", valid_out, mem_stall, alu_out); end
  endtask

  task automatic test_reset_mid_access();
    capture(1, 1, 0, 3'b010, 32'h500, 32'h0, 32'h5000, 5'd11, 4'd5, 1'b1, 1'b0);
    tick();
    #2 rst = 1'b0;
    #1;
    model_rdata = 32'h0;
    vecs++; if ({valid_out, mem_stall, data_mem_read, data_mem_write, br_en_out} !== 5'b0) begin errs++; $display("FAIL rstmid_ctl got %b want 00000", {valid_out, mem_stall, data_mem_read, data_mem_write, br_en_out}); end
    vecs++; if ({alu_out, pc_out, data_mem_address, mem_rdata_out} !== 128'h0 || data_mem_mbe !== 4'h0) begin errs++; $display("FAIL rstmid_data got alu=%h pc=%h mbe=%b want 0", alu_out, pc_out, data_mem_mbe); end
    @(negedge clk); rst = 1'b1;
    data_mem_resp = 1; data_mem_rdata = 32'h99;
    tick(); tick();
    data_mem_resp = 0;
    vecs++; if ({mem_stall, data_mem_read, valid_out} !== 3'b000) begin errs++; $display("FAIL rstmid_idle got %b want 000", {mem_stall, data_mem_read, valid_out}); end
    vecs++; if (mem_rdata_out !== 32'h0) begin errs++; $display("FAIL rstmid_resp_ignored got %h want 0", mem_rdata_out); end
  endtask

  task automatic test_misaligned();
    capture(1, 1, 0, 3'b010, 32'h101, 32'h0, 32'h6000, 5'd12, 4'd6, 1'b0, 1'b0);
    if (TRAP_EN) begin
      vecs++; if ({data_mem_read, mem_stall, misaligned_out} !== 3'b001) begin errs++; $display("FAIL mis_trap got %b want 001", {data_mem_read, mem_stall, misaligned_out}); end
      tick();
      vecs++; if (misaligned_out !== 1'b1) begin errs++; $display("FAIL mis_hold got %b want 1", misaligned_out); end
    end else begin
      vecs++; if ({data_mem_read, mem_stall, misaligned_out} !== 3'b110) begin errs++; $display("FAIL mis_issue got %b want 110", {data_mem_read, mem_stall, misaligned_out}); end
      vecs++; if (data_mem_mbe !== 4'b1111) begin errs++; $display("FAIL mis_mbe got %b want 1111", data_mem_mbe); end
      data_mem_resp = 1; data_mem_rdata = 32'h7; model_rdata = 32'h7;
      tick();
      data_mem_resp = 0;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      logic v, fl, mr, mw, br, killed, is_acc, is_trap, exp_valid;
      logic [2:0] f3;
      logic [31:0] alu, rs2, pc, rdata;
      logic [4:0] rd;
      logic [3:0] sel;
      int op, lat;
      v = ($urandom_range(0, 3) != 0); fl = ($urandom_range(0, 4) == 0);
      op = $urandom_range(0, 2); mr = (op == 1); mw = (op == 2);
      f3 = 3'($urandom_range(0, 7)); alu = $urandom; rs2 = $urandom; pc = $urandom;
      rd = 5'($urandom); sel = 4'($urandom); br = 1'($urandom);
      lat = $urandom_range(1, 4); rdata = $urandom;
      is_trap = TRAP_EN && v && !fl && (op != 0) && ref_misaligned(f3, alu);
      is_acc = v && !fl && (op != 0) && !is_trap;
      exp_valid = v && !fl;
      capture(v, mr, mw, f3, alu, rs2, pc, rd, sel, br, fl);
      vecs++; if ({mem_stall, data_mem_read, data_mem_write, misaligned_out} !== {is_acc, is_acc && mr, is_acc && mw, is_trap}) begin
        errs++; $display("FAIL rnd%0d_ctl got %b want %b", n, {mem_stall, data_mem_read, data_mem_write, misaligned_out}, {is_acc, is_acc && mr, is_acc && mw, is_trap}); end
      vecs++; if (data_mem_address !== {alu[31:2], 2'b00}) begin errs++; $display("FAIL rnd%0d_addr got %h want %h", n, data_mem_address, {alu[31:2], 2'b00}); end
      if (is_acc) begin
        vecs++; if (data_mem_mbe !== ref_mbe(f3, alu)) begin errs++; $display("FAIL rnd%0d_mbe f3=%b got %b want %b", n, f3, data_mem_mbe, ref_mbe(f3, alu)); end
        if (mw && size_of(f3) != 0) begin
          vecs++; if (data_mem_wdata !== ref_wdata(f3, rs2)) begin errs++; $display("FAIL rnd%0d_wdata got %h want %h", n, data_mem_wdata, ref_wdata(f3, rs2)); end
        end
        killed = 1'b0;
        for (int k = 1; k <= lat; k++) begin
          flush = ($urandom_range(0, 3) == 0);
          killed = killed || flush;
          load = 1'($urandom);
          if (k == lat) begin data_mem_resp = 1; data_mem_rdata = rdata; end
          tick();
          data_mem_resp = 0; flush = 0; load = 0;
          if (k < lat) begin
            vecs++; if (mem_stall !== 1'b1) begin errs++; $display("FAIL rnd%0d_stall_c%0d got %b want 1", n, k, mem_stall); end
          end
        end
        model_rdata = rdata;
        exp_valid = exp_valid && !killed;
      end
      if ($urandom_range(0, 2) == 0) begin
        alu_in = $urandom; valid_in = 1'($urandom);
        tick();
      end
      vecs++; if (mem_stall !== 1'b0 || valid_out !== exp_valid) begin errs++; $display("FAIL rnd%0d_end got s=%b v=%b want 0 %b", n, mem_stall, valid_out, exp_valid); end
      vecs++; if ({alu_out, pc_out, rd_out, regfilemux_sel_out, br_en_out} !== {alu, pc, rd, sel, br}) begin
        errs++; $display("FAIL rnd%0d_fields got alu=%h pc=%h want alu=%h pc=%h", n, alu_out, pc_out, alu, pc); end
      vecs++; if (mem_rdata_out !== model_rdata) begin errs++; $display("FAIL rnd%0d_rdata got %h want %h", n, mem_rdata_out, model_rdata); end
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_store_half();
    test_flush_in_access();
    test_reset_mid_access();
    test_misaligned();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
